// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_controller                                            |
// | Description : Pipeline sequencing unit for the 5-stage Abejaruco core.     |
// |               Counting register scoreboard, decode RAW detection, per-stage|
// |               stall/bubble/flush controls and a saturating stall counter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_controller #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 2,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs1,
  input  logic                      d_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs2,
  input  logic                      d_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] d_rd,
  input  logic                      d_reg_write,
  input  logic                      f_ready,
  input  logic                      m_busy,
  input  logic                      e_branch_taken,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      bubble_d,
  output logic                      bubble_e,
  output logic                      flush_fd,
  output logic                      freeze_em,
  output logic                      issue,
  output logic                      stall,
  output logic [PERF_WIDTH-1:0]     stall_count,
  output logic                      sb_error
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   err_vec;
  logic                  sb_error_q, sb_error_d;
  logic [PERF_WIDTH-1:0] stall_count_q, stall_count_d;

  logic wb_wr;
  logic sb_inc;
  logic hz_rs1, hz_rs2, raw;

  // A commit that actually updates an architectural register (r0 excluded).
  assign wb_wr  = wb_valid && wb_reg_write && (wb_rd != '0);
  // A decode instruction entering E that will write a real register.
  assign sb_inc = issue && d_reg_write && (d_rd != '0);

  // Per-register counter update and over/underflow detection.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
    if (i == 0) begin : g_r0
      assign cnt_d[i]   = '0;
      assign err_vec[i] = 1'b0;
      assign busy[i]    = 1'b0;
    end else begin : g_rn
      logic                 inc, dec, err;
      logic [CNT_WIDTH-1:0] nxt;
      assign inc = sb_inc && (d_rd == REG_ADDR_WIDTH'(i));
      assign dec = wb_wr && (wb_rd == REG_ADDR_WIDTH'(i));
      // Simultaneous inc/dec cancel; saturating ends flag an error instead of wrapping.
      always_comb begin
        nxt = cnt_q[i];
        err = 1'b0;
        if (inc && !dec) begin
          if (cnt_q[i] == CNT_MAX) err = 1'b1;
          else                     nxt = cnt_q[i] + 1'b1;
        end else if (dec && !inc) begin
          if (cnt_q[i] == '0) err = 1'b1;
          else                nxt = cnt_q[i] - 1'b1;
        end
      end
      assign cnt_d[i]   = nxt;
      assign err_vec[i] = err;
      assign busy[i]    = (cnt_q[i] != '0);
    end
  end

  // RAW detection; a same-cycle W write to the source is forwarded by the register file.
  always_comb begin
    hz_rs1 = d_rs1_used && (d_rs1 != '0) && busy[d_rs1] && !(wb_wr && (wb_rd == d_rs1));
    hz_rs2 = d_rs2_used && (d_rs2 != '0) && busy[d_rs2] && !(wb_wr && (wb_rd == d_rs2));
    raw    = d_valid && (hz_rs1 || hz_rs2);
  end

  // Prioritised stage controls: D-cache miss, taken branch, RAW stall, normal flow.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    bubble_d  = 1'b0;
    bubble_e  = 1'b0;
    flush_fd  = 1'b0;
    freeze_em = 1'b0;
    issue     = 1'b0;
    stall     = 1'b0;
    if (!reset) begin
      // everything held low while in reset
    end else if (m_busy) begin
      freeze_em = 1'b1;
      stall_f   = 1'b1;
      stall_d   = 1'b1;
    end else if (e_branch_taken) begin
      flush_fd  = 1'b1;
      bubble_e  = 1'b1;
    end else if (raw) begin
      stall     = 1'b1;
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      bubble_e  = 1'b1;
    end else begin
      issue     = d_valid;
      bubble_e  = !d_valid;
      stall_f   = !f_ready;
      bubble_d  = !f_ready;
    end
  end

  // Sticky error flag and saturating stall-cycle counter next state.
  always_comb begin
    sb_error_d    = sb_error_q | (|err_vec);
    stall_count_d = stall_count_q;
    if (stall_d && (stall_count_q != PERF_MAX)) stall_count_d = stall_count_q + 1'b1;
  end

  // State registers: scoreboard counters, error flag, performance counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      sb_error_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      sb_error_q    <= sb_error_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign sb_error    = sb_error_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_controller                                         |
// | Description : Directed self-checking bench for hazard_controller.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid, d_rs1_used, d_rs2_used, d_reg_write;
  logic [4:0]  d_rs1, d_rs2, d_rd, wb_rd;
  logic        f_ready, m_busy, e_branch_taken, wb_valid, wb_reg_write;
  logic        stall_f, stall_d, bubble_d, bubble_e, flush_fd, freeze_em, issue, stall;
  logic [31:0] stall_count;
  logic        sb_error;

  int total = 0;
  int bad   = 0;

  hazard_controller dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs1_used(d_rs1_used),
    .d_rs2(d_rs2), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_reg_write(d_reg_write),
    .f_ready(f_ready), .m_busy(m_busy), .e_branch_taken(e_branch_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_d(bubble_d), .bubble_e(bubble_e),
    .flush_fd(flush_fd), .freeze_em(freeze_em), .issue(issue), .stall(stall),
    .stall_count(stall_count), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change #1 after the edge, checks happen before the next
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_rs1 = 0; d_rs1_used = 0; d_rs2 = 0; d_rs2_used = 0;
    d_rd = 0; d_reg_write = 0; f_ready = 1; m_busy = 0; e_branch_taken = 0;
    wb_valid = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic dec_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic wr);
    d_valid = 1; d_rs1 = rs1; d_rs1_used = u1; d_rs2 = rs2; d_rs2_used = u2;
    d_rd = rd; d_reg_write = wr;
  endtask

  task automatic commit(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd; wb_reg_write = 1;
  endtask

  task automatic no_commit();
    wb_valid = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    f_ready = 0; m_busy = 1; d_valid = 1;
    #3;
    total++;
    if ({stall_f, stall_d, bubble_d, bubble_e, flush_fd, freeze_em, issue, stall} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000000",
        {stall_f, stall_d, bubble_d, bubble_e, flush_fd, freeze_em, issue, stall});
    end
    total++;
    if (stall_count !== 32'd0 || sb_error !== 1'b0) begin
      bad++; $display("FAIL reset_state got cnt=%0d err=%b want 0/0", stall_count, sb_error);
    end
    step();
    step();
    idle();
    reset = 1;
    #1;
  endtask

  task automatic test_nops();
    for (int k = 0; k < 4; k++) begin
      dec_instr(0, 1, 0, 1, 0, 1);
      #1;
      total++;
      if (stall !== 0 || issue !== 1 || bubble_e !== 0 || stall_d !== 0) begin
        bad++; $display("FAIL nop_%0d got stall=%b issue=%b bub_e=%b stall_d=%b want 0 1 0 0",
          k, stall, issue, bubble_e, stall_d);
      end
      step();
    end
    // instruction cache not ready: F held, D gets a nop, D still issues
    f_ready = 0;
    dec_instr(1, 1, 2, 1, 0, 0);
    #1;
    total++;
    if (stall_f !== 1 || bubble_d !== 1 || stall_d !== 0 || issue !== 1 || stall !== 0) begin
      bad++; $display("FAIL icache_wait got sf=%b bd=%b sd=%b iss=%b st=%b want 1 1 0 1 0",
        stall_f, bubble_d, stall_d, issue, stall);
    end
    step();
    f_ready = 1;
    total++;
    if (stall_count !== 32'd0) begin
      bad++; $display("FAIL nop_stall_count got=%0d want=0", stall_count);
    end
    idle();
  endtask

  task automatic test_raw();
    dec_instr(1, 1, 1, 1, 2, 1);      // add r2 <- r1, r1
    #1;
    total++;
    if (issue !== 1 || stall !== 0) begin
      bad++; $display("FAIL raw_producer got issue=%b stall=%b want 1 0", issue, stall);
    end
    step();
    dec_instr(2, 1, 2, 1, 3, 1);      // add r3 <- r2, r2
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (stall !== 1 || bubble_e !== 1 || issue !== 0 || stall_f !== 1 || stall_d !== 1) begin
        bad++; $display("FAIL raw_stall_%0d got st=%b be=%b iss=%b sf=%b sd=%b want 1 1 0 1 1",
          k, stall, bubble_e, issue, stall_f, stall_d);
      end
      step();
    end
    commit(2);                          // producer in W: write-through releases the consumer
    #1;
    total++;
    if (stall !== 0 || issue !== 1 || bubble_e !== 0) begin
      bad++; $display("FAIL raw_release got st=%b iss=%b be=%b want 0 1 0", stall, issue, bubble_e);
    end
    total++;
    if (stall_count !== 32'd2) begin
      bad++; $display("FAIL raw_stall_count got=%0d want=2", stall_count);
    end
    step();
    idle();
    commit(3);                          // drain consumer
    step();
    idle();
  endtask

  task automatic test_two_writers();
    dec_instr(0, 0, 0, 0, 5, 1);
    step();
    dec_instr(0, 0, 0, 0, 5, 1);
    step();
    idle();
    commit(5);
    #1;
    total++;
    if (issue !== 0 || bubble_e !== 1) begin
      bad++; $display("FAIL two_idle got iss=%b be=%b want 0 1", issue, bubble_e);
    end
    step();
    no_commit();
    dec_instr(5, 1, 0, 0, 0, 0);
    #1;
    total++;
    if (stall !== 1) begin
      bad++; $display("FAIL two_busy_after_first got stall=%b want 1", stall);
    end
    step();
    d_valid = 0;
    commit(5);
    step();
    no_commit();
    dec_instr(5, 1, 0, 0, 0, 0);
    #1;
    total++;
    if (stall !== 0 || issue !== 1 || sb_error !== 0) begin
      bad++; $display("FAIL two_cleared got st=%b iss=%b err=%b want 0 1 0", stall, issue, sb_error);
    end
    step();
    idle();
    total++;
    if (stall_count !== 32'd3) begin
      bad++; $display("FAIL two_stall_count got=%0d want=3", stall_count);
    end
  endtask

  task automatic test_dcache_miss();
    dec_instr(0, 0, 0, 0, 6, 1);
    step();
    dec_instr(6, 1, 0, 0, 0, 0);       // hazard on r6 sits in D
    m_busy = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) commit(6); else no_commit();
      #1;
      total++;
      if (freeze_em !== 1 || stall !== 0 || issue !== 0 || stall_f !== 1 || stall_d !== 1
          || bubble_e !== 0 || flush_fd !== 0 || bubble_d !== 0) begin
        bad++; $display("FAIL miss_%0d got fr=%b st=%b iss=%b sf=%b sd=%b be=%b ff=%b bd=%b",
          k, freeze_em, stall, issue, stall_f, stall_d, bubble_e, flush_fd, bubble_d);
      end
      step();
    end
    m_busy = 0;
    no_commit();
    #1;
    total++;
    if (stall !== 0 || issue !== 1 || freeze_em !== 0) begin
      bad++; $display("FAIL miss_release got st=%b iss=%b fr=%b want 0 1 0", stall, issue, freeze_em);
    end
    total++;
    if (stall_count !== 32'd7) begin
      bad++; $display("FAIL miss_stall_count got=%0d want=7", stall_count);
    end
    step();
    idle();
  endtask

  task automatic test_branch();
    dec_instr(0, 0, 0, 0, 8, 1);
    step();
    dec_instr(8, 1, 0, 0, 9, 1);       // RAW on r8, would write r9
    e_branch_taken = 1;
    #1;
    total++;
    if (flush_fd !== 1 || bubble_e !== 1 || stall !== 0 || issue !== 0
        || stall_f !== 0 || stall_d !== 0) begin
      bad++; $display("FAIL branch got ff=%b be=%b st=%b iss=%b sf=%b sd=%b want 1 1 0 0 0 0",
        flush_fd, bubble_e, stall, issue, stall_f, stall_d);
    end
    step();
    e_branch_taken = 0;
    dec_instr(9, 1, 0, 0, 0, 0);       // r9 must not have been marked busy
    #1;
    total++;
    if (stall !== 0 || issue !== 1) begin
      bad++; $display("FAIL branch_no_inc got st=%b iss=%b want 0 1", stall, issue);
    end
    step();
    idle();
    commit(8);
    step();
    idle();
    total++;
    if (stall_count !== 32'd7 || sb_error !== 0) begin
      bad++; $display("FAIL branch_state got cnt=%0d err=%b want 7 0", stall_count, sb_error);
    end
  endtask

  task automatic test_fault();
    commit(7);                          // r7 has no writer in flight
    #1;
    total++;
    if (sb_error !== 0) begin
      bad++; $display("FAIL underflow_pre got=%b want=0", sb_error);
    end
    step();
    no_commit();
    step();
    step();
    total++;
    if (sb_error !== 1) begin
      bad++; $display("FAIL underflow_sticky got=%b want=1", sb_error);
    end
    dec_instr(0, 0, 0, 0, 10, 1);
    step();
    dec_instr(10, 1, 0, 0, 0, 0);
    #1;
    total++;
    if (stall !== 1) begin
      bad++; $display("FAIL midstall got stall=%b want 1", stall);
    end
    step();
    total++;
    if (stall_count !== 32'd8) begin
      bad++; $display("FAIL midstall_count got=%0d want=8", stall_count);
    end
    #2;
    reset = 0;                          // asynchronous, between edges
    #1;
    total++;
    if (stall_count !== 0 || sb_error !== 0 || stall !== 0 || stall_d !== 0 || stall_f !== 0
        || bubble_e !== 0 || issue !== 0) begin
      bad++; $display("FAIL async_reset got cnt=%0d err=%b st=%b sd=%b sf=%b be=%b iss=%b",
        stall_count, sb_error, stall, stall_d, stall_f, bubble_e, issue);
    end
    step();
    reset = 1;
    #1;
    total++;
    if (stall !== 0 || issue !== 1) begin
      bad++; $display("FAIL sb_cleared got st=%b iss=%b want 0 1", stall, issue);
    end
    step();
    // overflow: four writers to r11 exceed a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      dec_instr(0, 0, 0, 0, 11, 1);
      step();
      if (k == 2) begin
        total++;
        if (sb_error !== 0) begin
          bad++; $display("FAIL overflow_pre got=%b want=0", sb_error);
        end
      end
    end
    idle();
    total++;
    if (sb_error !== 1) begin
      bad++; $display("FAIL overflow got=%b want=1", sb_error);
    end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_raw();
    test_two_writers();
    test_dcache_miss();
    test_branch();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
